// File: rtl/pixel_sample.sv
// rtl/pixel_sample.sv - pixel-array sampling sequencer for the imager core
//
// Raster-scans a PIXEL_NUM_ROW x PIXEL_NUM_COL array while enabled. It drives
// one-hot row/col selects, a per-phase start strobe and a sampling clock to the
// analog front end. It also supports correlated double sampling, a
// single-pixel park mode and a row/col disable mask.
//
// Optional build macro: SAMPLE_FRAME_DONE_EN adds the frame_done output.
//
// Ports:
//   clk                          system clock
//   reset                        synchronous, active-high reset
//   enable                       level, high = sampling active
//   single_pixel_en              park on the programmed address instead of scanning
//   pixel_disable                force row/col to 0, sequencing continues
//   correlated_double_sampling   two phases (reset, signal) per pixel
//   single_pixel_row_addr [7:0]  row index for single-pixel mode
//   single_pixel_col_addr [7:0]  col index for single-pixel mode
//   row   [PIXEL_NUM_ROW-1:0]    one-hot row select (registered)
//   col   [PIXEL_NUM_COL-1:0]    one-hot col select (registered)
//   start                        one-cycle strobe on the first cycle of each phase
//   clk_out                      sampling clock, high for the first half of each phase
//   frame_done                   (SAMPLE_FRAME_DONE_EN only) last cycle of a scanned frame

module pixel_sample #(
  parameter int PIXEL_NUM_ROW       = 7,
  parameter int PIXEL_NUM_COL       = 16,
  parameter int PIXEL_ADDR_BITS_ROW = $clog2(PIXEL_NUM_ROW),
  parameter int PIXEL_ADDR_BITS_COL = $clog2(PIXEL_NUM_COL),
  parameter int DWELL_CYCLES        = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     enable,
  input  logic                     single_pixel_en,
  input  logic                     pixel_disable,
  input  logic                     correlated_double_sampling,
  input  logic [7:0]               single_pixel_row_addr,
  input  logic [7:0]               single_pixel_col_addr,
  output logic [PIXEL_NUM_ROW-1:0] row,
  output logic [PIXEL_NUM_COL-1:0] col,
  output logic                     start,
  output logic                     clk_out
`ifdef SAMPLE_FRAME_DONE_EN
  ,
  output logic                     frame_done
`endif
);

  // DWELL_CYCLES must be even and >= 2.
  localparam int DWELL_BITS = (DWELL_CYCLES > 2) ? $clog2(DWELL_CYCLES) : 1;

  localparam logic [DWELL_BITS-1:0]          DWELL_LAST = DWELL_BITS'(DWELL_CYCLES - 1);
  localparam logic [DWELL_BITS-1:0]          DWELL_HALF = DWELL_BITS'(DWELL_CYCLES / 2);
  localparam logic [PIXEL_ADDR_BITS_ROW-1:0] ROW_LAST   = PIXEL_ADDR_BITS_ROW'(PIXEL_NUM_ROW - 1);
  localparam logic [PIXEL_ADDR_BITS_COL-1:0] COL_LAST   = PIXEL_ADDR_BITS_COL'(PIXEL_NUM_COL - 1);
  localparam logic [7:0]                     ROW_LIMIT  = 8'(PIXEL_NUM_ROW);
  localparam logic [7:0]                     COL_LIMIT  = 8'(PIXEL_NUM_COL);

  typedef enum logic {
    S_IDLE   = 1'b0,
    S_ACTIVE = 1'b1
  } state_e;

  // Sequencer state
  state_e                         state_q,   state_d;
  logic [PIXEL_ADDR_BITS_ROW-1:0] row_idx_q, row_idx_d;
  logic [PIXEL_ADDR_BITS_COL-1:0] col_idx_q, col_idx_d;
  logic [DWELL_BITS-1:0]          dwell_q,   dwell_d;
  logic                           phase_q,   phase_d;
  logic                           cds_q,     cds_d;      // CDS mode latched for the current pixel
  logic                           sp_mode_q, sp_mode_d;  // single-pixel park in effect
  logic [7:0]                     sp_row_q,  sp_row_d;
  logic [7:0]                     sp_col_q,  sp_col_d;

  // Registered outputs
  logic [PIXEL_NUM_ROW-1:0]       row_q,     row_d;
  logic [PIXEL_NUM_COL-1:0]       col_q,     col_d;
  logic                           start_q,   start_d;
  logic                           clk_out_q, clk_out_d;
`ifdef SAMPLE_FRAME_DONE_EN
  logic                           frame_done_q, frame_done_d;
`endif

  logic                           dwell_last;
  logic                           pixel_last;
  logic                           active_d;
  logic [7:0]                     row_ptr;
  logic [7:0]                     col_ptr;
  logic                           ptr_valid;

  // --------------------------------------------------------------------------
  // State register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= S_IDLE;
      row_idx_q    <= '0;
      col_idx_q    <= '0;
      dwell_q      <= '0;
      phase_q      <= 1'b0;
      cds_q        <= 1'b0;
      sp_mode_q    <= 1'b0;
      sp_row_q     <= '0;
      sp_col_q     <= '0;
      row_q        <= '0;
      col_q        <= '0;
      start_q      <= 1'b0;
      clk_out_q    <= 1'b0;
`ifdef SAMPLE_FRAME_DONE_EN
      frame_done_q <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      row_idx_q    <= row_idx_d;
      col_idx_q    <= col_idx_d;
      dwell_q      <= dwell_d;
      phase_q      <= phase_d;
      cds_q        <= cds_d;
      sp_mode_q    <= sp_mode_d;
      sp_row_q     <= sp_row_d;
      sp_col_q     <= sp_col_d;
      row_q        <= row_d;
      col_q        <= col_d;
      start_q      <= start_d;
      clk_out_q    <= clk_out_d;
`ifdef SAMPLE_FRAME_DONE_EN
      frame_done_q <= frame_done_d;
`endif
    end
  end

  // --------------------------------------------------------------------------
  // Next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    state_d    = state_q;
    row_idx_d  = row_idx_q;
    col_idx_d  = col_idx_q;
    dwell_d    = dwell_q;
    phase_d    = phase_q;
    cds_d      = cds_q;
    sp_mode_d  = sp_mode_q;

    dwell_last = (dwell_q == DWELL_LAST);
    pixel_last = dwell_last && (phase_q || !cds_q);

    // The parked address follows the inputs every cycle while the mode is
    // requested. Once the mode is released, the last address is held until
    // the phase boundary where scanning resumes.
    sp_row_d   = single_pixel_en ? single_pixel_row_addr : sp_row_q;
    sp_col_d   = single_pixel_en ? single_pixel_col_addr : sp_col_q;

    unique case (state_q)
      S_IDLE: begin
        row_idx_d = '0;
        col_idx_d = '0;
        dwell_d   = '0;
        phase_d   = 1'b0;
        cds_d     = 1'b0;
        sp_mode_d = 1'b0;
        if (enable) begin
          state_d   = S_ACTIVE;
          cds_d     = correlated_double_sampling;
          sp_mode_d = single_pixel_en;
        end
      end

      S_ACTIVE: begin
        if (!enable) begin
          // Enable loss takes priority over any boundary in the same cycle.
          state_d   = S_IDLE;
          row_idx_d = '0;
          col_idx_d = '0;
          dwell_d   = '0;
          phase_d   = 1'b0;
          cds_d     = 1'b0;
          sp_mode_d = 1'b0;
        end else begin
          // Entering single-pixel mode is immediate. Leaving it waits for a
          // phase boundary so a phase is never cut short.
          sp_mode_d = single_pixel_en || (sp_mode_q && !dwell_last);
          dwell_d   = dwell_last ? '0 : dwell_q + 1'b1;

          if (dwell_last) begin
            if (pixel_last || (sp_mode_q && !sp_mode_d)) begin
              phase_d = 1'b0;
              cds_d   = correlated_double_sampling;
            end else begin
              phase_d = 1'b1;
            end
          end

          // The scan pointer is parked at (0,0) during single-pixel mode,
          // so the scan resumes from the start of the array.
          if (sp_mode_d || sp_mode_q) begin
            row_idx_d = '0;
            col_idx_d = '0;
          end else if (pixel_last) begin
            if (col_idx_q == COL_LAST) begin
              col_idx_d = '0;
              row_idx_d = (row_idx_q == ROW_LAST) ? '0 : row_idx_q + 1'b1;
            end else begin
              col_idx_d = col_idx_q + 1'b1;
            end
          end
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  // --------------------------------------------------------------------------
  // Output logic
  // --------------------------------------------------------------------------
  // Outputs are decoded from the next-state values. This way the registered
  // selects line up with the counters they describe.
  always_comb begin
    active_d  = (state_d == S_ACTIVE);
    row_ptr   = sp_mode_d ? sp_row_d : 8'(row_idx_d);
    col_ptr   = sp_mode_d ? sp_col_d : 8'(col_idx_d);
    ptr_valid = (row_ptr < ROW_LIMIT) && (col_ptr < COL_LIMIT);

    row_d     = '0;
    col_d     = '0;
    if (active_d && !pixel_disable && ptr_valid) begin
      row_d[row_ptr[PIXEL_ADDR_BITS_ROW-1:0]] = 1'b1;
      col_d[col_ptr[PIXEL_ADDR_BITS_COL-1:0]] = 1'b1;
    end

    start_d   = active_d && (dwell_d == '0);
    clk_out_d = active_d && (dwell_d < DWELL_HALF);

`ifdef SAMPLE_FRAME_DONE_EN
    frame_done_d = active_d && !sp_mode_d &&
                   (row_idx_d == ROW_LAST) && (col_idx_d == COL_LAST) &&
                   (dwell_d == DWELL_LAST) && (phase_d || !cds_d);
`endif
  end

  assign row     = row_q;
  assign col     = col_q;
  assign start   = start_q;
  assign clk_out = clk_out_q;
`ifdef SAMPLE_FRAME_DONE_EN
  assign frame_done = frame_done_q;
`endif

endmodule

// File: tb/tb_pixel_sample.sv
// tb/tb_pixel_sample.sv - directed vector bench for pixel_sample

module tb_pixel_sample;

  logic        clk = 1'b0;
  logic        reset;
  logic        enable;
  logic        single_pixel_en;
  logic        pixel_disable;
  logic        correlated_double_sampling;
  logic [7:0]  single_pixel_row_addr;
  logic [7:0]  single_pixel_col_addr;
  logic [6:0]  row;
  logic [15:0] col;
  logic        start;
  logic        clk_out;
`ifdef SAMPLE_FRAME_DONE_EN
  logic        frame_done;
  int          fd_count = 0;
`endif

  always #5 clk = ~clk;

  pixel_sample dut (
    .clk                        (clk),
    .reset                      (reset),
    .enable                     (enable),
    .single_pixel_en            (single_pixel_en),
    .pixel_disable              (pixel_disable),
    .correlated_double_sampling (correlated_double_sampling),
    .single_pixel_row_addr      (single_pixel_row_addr),
    .single_pixel_col_addr      (single_pixel_col_addr),
    .row                        (row),
    .col                        (col),
    .start                      (start),
    .clk_out                    (clk_out)
`ifdef SAMPLE_FRAME_DONE_EN
    ,
    .frame_done                 (frame_done)
`endif
  );

`ifdef SAMPLE_FRAME_DONE_EN
  always @(posedge clk) if (!reset && frame_done) fd_count <= fd_count + 1;
`endif

  typedef struct {
    logic        cds;
    logic        dis;
    logic        sp;
    logic [7:0]  ra;
    logic [7:0]  ca;
    int          k;      // target cycle index counted from the first active cycle
    logic [6:0]  er;
    logic [15:0] ec;
    logic        es;
    logic        eclk;
  } vec_t;

  vec_t tbl[$];
  int   n_checks = 0;
  int   n_pass   = 0;
  int   k        = 0;

  function automatic vec_t mk(input logic cds, input logic dis, input logic sp,
                              input logic [7:0] ra, input logic [7:0] ca, input int kk,
                              input logic [6:0] er, input logic [15:0] ec,
                              input logic es, input logic eclk);
    vec_t v;
    v.cds = cds; v.dis = dis; v.sp = sp; v.ra = ra; v.ca = ca; v.k = kk;
    v.er = er; v.ec = ec; v.es = es; v.eclk = eclk;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  task automatic chk_all(input string name, input logic [6:0] er, input logic [15:0] ec,
                         input logic es, input logic eclk);
    chk({name, "_row"},     32'(row),     32'(er));
    chk({name, "_col"},     32'(col),     32'(ec));
    chk({name, "_start"},   32'(start),   32'(es));
    chk({name, "_clk_out"}, 32'(clk_out), 32'(eclk));
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    // Continuous scan from the first active cycle (k=1). Phase length is 8.
    tbl.push_back(mk(0,0,0,8'd0,8'd0, 121, 7'h01,16'h8000,1,1)); // pixel 15
    tbl.push_back(mk(0,0,0,8'd0,8'd0, 125, 7'h01,16'h8000,0,0)); // clk_out low half
    tbl.push_back(mk(0,0,0,8'd0,8'd0, 129, 7'h02,16'h0001,1,1)); // row step
    tbl.push_back(mk(0,0,0,8'd0,8'd0, 896, 7'h40,16'h8000,0,0)); // last cycle of frame
    tbl.push_back(mk(0,0,0,8'd0,8'd0, 897, 7'h01,16'h0001,1,1)); // wrap to (0,0)
    // CDS on from k=897; it takes effect at pixel 1 (k=905), 16 cycles per pixel.
    tbl.push_back(mk(1,0,0,8'd0,8'd0, 905, 7'h01,16'h0002,1,1));
    tbl.push_back(mk(1,0,0,8'd0,8'd0, 913, 7'h01,16'h0002,1,1)); // second phase
    tbl.push_back(mk(1,0,0,8'd0,8'd0, 917, 7'h01,16'h0002,0,0));
    tbl.push_back(mk(1,0,0,8'd0,8'd0, 921, 7'h01,16'h0004,1,1));
    tbl.push_back(mk(1,0,0,8'd0,8'd0,1145, 7'h02,16'h0001,1,1)); // pixel 16
    // CDS off mid-pixel: pixel 16 still gets two phases.
    tbl.push_back(mk(0,0,0,8'd0,8'd0,1153, 7'h02,16'h0001,1,1));
    tbl.push_back(mk(0,0,0,8'd0,8'd0,1161, 7'h02,16'h0002,1,1));
    tbl.push_back(mk(0,0,0,8'd0,8'd0,1169, 7'h02,16'h0004,1,1));
    // pixel_disable: selects cleared, timing continues.
    tbl.push_back(mk(0,1,0,8'd0,8'd0,1170, 7'h00,16'h0000,0,1));
    tbl.push_back(mk(0,1,0,8'd0,8'd0,1177, 7'h00,16'h0000,1,1));
    tbl.push_back(mk(0,0,0,8'd0,8'd0,1178, 7'h02,16'h0008,0,1)); // advanced pixel 19
    // Single-pixel mode.
    tbl.push_back(mk(0,0,1,8'd3,8'd7,1179, 7'h08,16'h0080,0,1));
    tbl.push_back(mk(0,0,1,8'd3,8'd7,1185, 7'h08,16'h0080,1,1));
    tbl.push_back(mk(0,0,1,8'd9,8'd7,1186, 7'h00,16'h0000,0,1)); // out-of-range row
    tbl.push_back(mk(0,0,1,8'd9,8'd7,1193, 7'h00,16'h0000,1,1));
    tbl.push_back(mk(0,0,1,8'd6,8'd15,1194,7'h40,16'h8000,0,1));
    tbl.push_back(mk(0,0,0,8'd6,8'd15,1201,7'h01,16'h0001,1,1)); // resume at (0,0)
    tbl.push_back(mk(0,0,0,8'd6,8'd15,1209,7'h01,16'h0002,1,1));

    reset = 1'b1;
    enable = 1'b1;
    single_pixel_en = 1'b0;
    pixel_disable = 1'b0;
    correlated_double_sampling = 1'b0;
    single_pixel_row_addr = 8'd0;
    single_pixel_col_addr = 8'd0;

    for (int i = 0; i < 10; i++) begin
      step(1);
      chk($sformatf("reset_c%0d", i), 32'({row, col, start, clk_out}), 32'd0);
    end
    reset = 1'b0;

    // First 16 active cycles: two pixels, phase timing cycle by cycle.
    for (int i = 1; i <= 16; i++) begin
      step(1);
      k = i;
      chk_all($sformatf("scan_k%0d", i), 7'h01, (i <= 8) ? 16'h0001 : 16'h0002,
              ((i - 1) % 8) == 0, ((i - 1) % 8) < 4);
    end

    for (int i = 0; i < tbl.size(); i++) begin
      correlated_double_sampling = tbl[i].cds;
      pixel_disable              = tbl[i].dis;
      single_pixel_en            = tbl[i].sp;
      single_pixel_row_addr      = tbl[i].ra;
      single_pixel_col_addr      = tbl[i].ca;
      step(tbl[i].k - k);
      k = tbl[i].k;
      chk_all($sformatf("vec%0d_k%0d", i, k), tbl[i].er, tbl[i].ec, tbl[i].es, tbl[i].eclk);
    end

`ifdef SAMPLE_FRAME_DONE_EN
    chk("frame_done_count", 32'(fd_count), 32'd1);
`endif

    // Enable dropped mid-pixel, then raised again 50 cycles later.
    step(3);
    enable = 1'b0;
    step(1);
    chk_all("idle_first", 7'h00, 16'h0000, 1'b0, 1'b0);
    step(49);
    chk_all("idle_last", 7'h00, 16'h0000, 1'b0, 1'b0);
    enable = 1'b1;
    step(1);
    chk_all("restart_k1", 7'h01, 16'h0001, 1'b1, 1'b1);
    step(1);
    chk_all("restart_k2", 7'h01, 16'h0001, 1'b0, 1'b1);
    step(6);
    chk_all("restart_k8", 7'h01, 16'h0001, 1'b0, 1'b0);

    // Enable falls exactly on the phase boundary, so the DUT must go idle.
    enable = 1'b0;
    step(1);
    chk_all("boundary_drop", 7'h00, 16'h0000, 1'b0, 1'b0);
    enable = 1'b1;
    step(1);
    chk_all("boundary_restart", 7'h01, 16'h0001, 1'b1, 1'b1);

    // A reset asserted while active clears all outputs.
    reset = 1'b1;
    step(1);
    chk_all("midrun_reset", 7'h00, 16'h0000, 1'b0, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
